seven_segment_scanner: RTL and testbench

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/seven_segment_scanner.sv | 158 +++++++++++++++
 tb/tb_seven_segment_scanner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
`timescale 1ns/1ps
// seven_segment_scanner
//   Time-multiplexes a frame of NUM_DIGITS BCD digits onto one shared segment
//   decoder. Each digit owns a slot of SLOT_CYCLES clocks; its anode is held
//   off for the first BLANK_CYCLES of the slot to suppress ghosting. New
//   frames are double-buffered and only swapped in at scan wrap, so a frame
//   never tears mid-scan.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   frame_load   one-cycle strobe capturing frame_bcd/frame_dp/frame_en
//   frame_bcd    digit codes, digit i in [4i+3:4i]
//   frame_dp     decimal point per digit, 1 = lit
//   frame_en     digit enable, 0 = digit dark for its slot
//   BCD          code of the current digit (registered)
//   dp           decimal point of the current digit (registered)
//   anode        active-low digit select, at most one bit low (registered)
//   digit_idx    index of the current slot
//   frame_done   one-cycle pulse in the cycle after each scan wrap
module seven_segment_scanner #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SLOT_CYCLES  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_load,
    input  logic [4*NUM_DIGITS-1:0] frame_bcd,
    input  logic [NUM_DIGITS-1:0]   frame_dp,
    input  logic [NUM_DIGITS-1:0]   frame_en,
    output logic [3:0]              BCD,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [2:0]              digit_idx,
    output logic                    frame_done
);

    localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [4*NUM_DIGITS-1:0] DASH_FRAME = {NUM_DIGITS{4'ha}};

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] act_bcd_q, act_bcd_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
    logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [3:0]              bcd_q, bcd_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    done_q, done_d;
    logic                    slot_end;
    logic                    scan_wrap;

    always_comb begin
        slot_end  = (cnt_q == SLOT_LAST);
        scan_wrap = slot_end && (idx_q == IDX_LAST);

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 3'd1;
        end

        act_bcd_d    = act_bcd_q;
        act_dp_d     = act_dp_q;
        act_en_d     = act_en_q;
        pend_bcd_d   = pend_bcd_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_valid_d = pend_valid_q;

        if (frame_load && !scan_wrap) begin
            pend_bcd_d   = frame_bcd;
            pend_dp_d    = frame_dp;
            pend_en_d    = frame_en;
            pend_valid_d = 1'b1;
        end

        // A load landing exactly on the wrap edge bypasses the pending buffer
        // so it is shown starting with digit 0 of the scan that begins now.
        if (scan_wrap) begin
            pend_valid_d = 1'b0;
            if (frame_load) begin
                act_bcd_d = frame_bcd;
                act_dp_d  = frame_dp;
                act_en_d  = frame_en;
            end else if (pend_valid_q) begin
                act_bcd_d = pend_bcd_q;
                act_dp_d  = pend_dp_q;
                act_en_d  = pend_en_q;
            end
        end

        // Outputs are registered from next-state values so BCD/dp/anode move
        // on the same edge as digit_idx and the low window is exactly
        // SLOT_CYCLES-BLANK_CYCLES cycles.
        bcd_d   = bcd_q;
        dp_d    = dp_q;
        anode_d = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == 3'(i)) begin
                bcd_d = act_bcd_d[4*i +: 4];
                dp_d  = act_dp_d[i];
                if (act_en_d[i] && (cnt_d >= BLANK_END)) begin
                    anode_d[i] = 1'b0;
                end
            end
        end

        done_d = scan_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_bcd_q    <= DASH_FRAME;
            act_dp_q     <= '0;
            act_en_q     <= '1;
            pend_bcd_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_valid_q <= 1'b0;
            bcd_q        <= 4'ha;
            dp_q         <= 1'b0;
            anode_q      <= '1;
            done_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_bcd_q    <= act_bcd_d;
            act_dp_q     <= act_dp_d;
            act_en_q     <= act_en_d;
            pend_bcd_q   <= pend_bcd_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_valid_q <= pend_valid_d;
            bcd_q        <= bcd_d;
            dp_q         <= dp_d;
            anode_q      <= anode_d;
            done_q       <= done_d;
        end
    end

    assign BCD        = bcd_q;
    assign dp         = dp_q;
    assign anode      = anode_q;
    assign digit_idx  = idx_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
`timescale 1ns/1ps
// tb_seven_segment_scanner
//   Directed and random frame loads against a time-based reference model:
//   after clock edge e since reset release, the slot counter is e mod S, the
//   digit is (e div S) mod N and a scan wraps whenever e is a multiple of N*S.
module tb_seven_segment_scanner;

    localparam int unsigned N    = 4;
    localparam int unsigned S    = 8;
    localparam int unsigned B    = 2;
    localparam int unsigned SCAN = N * S;

    logic           clk        = 1'b0;
    logic           rst_n      = 1'b1;
    logic           frame_load = 1'b0;
    logic [4*N-1:0] frame_bcd  = '0;
    logic [N-1:0]   frame_dp   = '0;
    logic [N-1:0]   frame_en   = '0;
    logic [3:0]     BCD;
    logic           dp;
    logic [N-1:0]   anode;
    logic [2:0]     digit_idx;
    logic           frame_done;

    seven_segment_scanner #(
        .NUM_DIGITS  (N),
        .SLOT_CYCLES (S),
        .BLANK_CYCLES(B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_load (frame_load),
        .frame_bcd  (frame_bcd),
        .frame_dp   (frame_dp),
        .frame_en   (frame_en),
        .BCD        (BCD),
        .dp         (dp),
        .anode      (anode),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   idx;
        logic [3:0]   bcd;
        logic         dp;
        logic [N-1:0] an;
        logic         fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int unsigned e;
    logic [3:0]  m_bcd[N];
    logic [N-1:0] m_dp;
    logic [N-1:0] m_en;
    logic [3:0]  p_bcd[N];
    logic [N-1:0] p_dp;
    logic [N-1:0] p_en;
    logic        p_valid;

    task automatic chk(input string name, input int unsigned got, input int unsigned want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_bcd[i] = 4'ha;
            p_bcd[i] = 4'h0;
        end
        m_dp    = '0;
        m_en    = '1;
        p_dp    = '0;
        p_en    = '0;
        p_valid = 1'b0;
        e       = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_anode"}, 32'(anode), 32'hf);
        chk({tag, "_bcd"}, 32'(BCD), 32'ha);
        chk({tag, "_dp"}, 32'(dp), 32'h0);
        chk({tag, "_idx"}, 32'(digit_idx), 32'h0);
        chk({tag, "_done"}, 32'(frame_done), 32'h0);
        chk({tag, "_pending"}, 32'(dut.pend_valid_q), 32'h0);
        chk({tag, "_count"}, 32'(dut.cnt_q), 32'h0);
    endtask

    // Called at a negedge; drives one clock, updates the model, queues the
    // expected outputs and returns at the following negedge.
    task automatic cycle(input logic ld, input logic [4*N-1:0] b,
                         input logic [N-1:0] d, input logic [N-1:0] en);
        exp_t        x;
        int unsigned cnt;
        int unsigned idx;
        bit          wrap;
        frame_load = ld;
        frame_bcd  = b;
        frame_dp   = d;
        frame_en   = en;
        @(posedge clk);
        e++;
        wrap = (e % SCAN == 0);
        if (ld) begin
            if (wrap) begin
                for (int i = 0; i < N; i++) m_bcd[i] = b[4*i +: 4];
                m_dp    = d;
                m_en    = en;
                p_valid = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) p_bcd[i] = b[4*i +: 4];
                p_dp    = d;
                p_en    = en;
                p_valid = 1'b1;
            end
        end else if (wrap && p_valid) begin
            for (int i = 0; i < N; i++) m_bcd[i] = p_bcd[i];
            m_dp    = p_dp;
            m_en    = p_en;
            p_valid = 1'b0;
        end
        cnt   = e % S;
        idx   = (e / S) % N;
        x.idx = 3'(idx);
        x.bcd = m_bcd[idx];
        x.dp  = m_dp[idx];
        x.an  = (cnt >= B && m_en[idx]) ? ~(N'(1) << idx) : '1;
        x.fd  = wrap;
        exp_q.push_back(x);
        @(negedge clk);
        frame_load = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) cycle(1'b0, '0, '0, '0);
    endtask

    // Load so that the strobe is sampled on the edge with e mod SCAN == k.
    task automatic load_at(input int unsigned k, input logic [4*N-1:0] b,
                           input logic [N-1:0] d, input logic [N-1:0] en);
        while (((e + 1) % SCAN) != k) cycle(1'b0, '0, '0, '0);
        cycle(1'b1, b, d, en);
    endtask

    // Scoreboard monitor
    exp_t mon_x;
    exp_t mon_g;
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            mon_g = {digit_idx, BCD, dp, anode, frame_done};
            checks++;
            if (mon_g !== mon_x) begin
                errors++;
                $display("FAIL slot_out: got idx=%0d bcd=%h dp=%b an=%b fd=%b expected idx=%0d bcd=%h dp=%b an=%b fd=%b",
                         mon_g.idx, mon_g.bcd, mon_g.dp, mon_g.an, mon_g.fd,
                         mon_x.idx, mon_x.bcd, mon_x.dp, mon_x.an, mon_x.fd);
            end
        end
    end

    // Anode invariants: never more than one digit selected, and every low
    // window lasts S-B cycles.
    int run_len = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else begin
            checks++;
            if ($countones(~anode) > 1) begin
                errors++;
                $display("FAIL anode_onehot: got %b expected at most one 0", anode);
            end
            if (anode != '1) begin
                run_len++;
            end else if (run_len != 0) begin
                checks++;
                if (run_len != int'(S - B)) begin
                    errors++;
                    $display("FAIL anode_window: got %0d cycles expected %0d", run_len, S - B);
                end
                run_len = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Free-running scan of the reset frame
        idle(SCAN + 1);

        // Load in slot 1; shown from the next scan
        load_at(10, 16'h4321, 4'b0010, 4'hF);
        idle(2 * SCAN);

        // Two loads in one scan: only the second is displayed
        load_at(5, 16'h1111, 4'b0000, 4'hF);
        load_at(20, 16'h2222, 4'b0101, 4'hF);
        idle(SCAN + 4);

        // Load coinciding with the wrap edge goes straight to the display
        load_at(0, 16'h9876, 4'b1000, 4'hF);
        chk("wrap_load_pending", 32'(dut.pend_valid_q), 32'(p_valid));
        idle(SCAN);

        // Digit 2 disabled
        load_at(9, 16'h5a5a, 4'b0001, 4'b1011);
        idle(2 * SCAN);

        // Asynchronous reset mid-slot 2 with a frame pending
        load_at(12, 16'hbeef, 4'b1111, 4'hF);
        while ((e % SCAN) != 18) cycle(1'b0, '0, '0, '0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 check_reset("midslot");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(2 * SCAN);

        // Random loads with random enables
        repeat (640) begin
            cycle(($urandom_range(0, 11) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
        end
        idle(2);

        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
